// File: rtl/uart_alu.sv
// UART coprocessor: receives 8N1 command packets (echo / 32-bit add / 32-bit multiply)
// and returns the results on the serial TX line.
module uart_alu #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic tx_o
);

  localparam int unsigned BitCycles  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned HalfCycles = BitCycles / 2;
  localparam int unsigned CntW       = $clog2(BitCycles + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCycles - 1);
  localparam logic [7:0] OpEcho = 8'hEC;
  localparam logic [7:0] OpAdd  = 8'hAD;
  localparam logic [7:0] OpMul  = 8'h88;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;
  typedef enum logic {TxIdle, TxBusy} tx_state_e;
  typedef enum logic [2:0] {CtlIdle, CtlHdr, CtlPayload, CtlExec, CtlResp} ctl_state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid;

  logic [7:0] fifo_mem_q [4];
  logic [1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0] fifo_wdata, fifo_rdata;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bits_q, tx_bits_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d, tx_load;

  ctl_state_e ctl_state_q, ctl_state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] len_q, len_d, byte_cnt_q, byte_cnt_d, len_full;
  logic        err_q, err_d, is_arith;
  logic [31:0] acc_q, acc_d, opnd_q, opnd_d, opnd_new, resp_shift;
  logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [5:0]  mul_cnt_q, mul_cnt_d;
  logic [1:0]  resp_idx_q, resp_idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CntW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RxIdle : RxData;  // high at mid-start means a glitch
      end
      RxData: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
      end
      RxStop: if (rx_cnt_q == BitLast) begin
        rx_valid   = rx_sync_q;
        rx_state_d = rx_sync_q ? RxIdle : RxWait;
      end
      RxWait: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign fifo_full  = (fifo_cnt_q == 3'd4);
  assign fifo_empty = (fifo_cnt_q == 3'd0);
  assign fifo_rdata = fifo_mem_q[fifo_rd_q];

  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push && !fifo_full) begin
      fifo_wr_d  = fifo_wr_q + 2'd1;
      fifo_cnt_d = fifo_cnt_d + 3'd1;
    end
    if (fifo_pop) begin
      fifo_rd_d  = fifo_rd_q + 2'd1;
      fifo_cnt_d = fifo_cnt_d - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push && !fifo_full) fifo_mem_q[fifo_wr_q] <= fifo_wdata;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CntW'(1);
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_d    = 1'b1;
        tx_load = !fifo_empty;
      end
      TxBusy: if (tx_cnt_q == BitLast) begin
        tx_cnt_d = '0;
        if (tx_bits_q == 4'd0) begin
          // End of stop bit: chain straight into the next frame if one is queued
          tx_load    = !fifo_empty;
          tx_state_d = TxIdle;
        end else begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bits_d  = tx_bits_q - 4'd1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    fifo_pop = tx_load;
    if (tx_load) begin
      tx_d       = 1'b0;
      tx_shift_d = {1'b1, fifo_rdata};
      tx_bits_d  = 4'd9;
      tx_cnt_d   = '0;
      tx_state_d = TxBusy;
    end
  end

  assign tx_o       = tx_q;
  assign len_full   = {rx_shift_q, len_q[7:0]};
  assign opnd_new   = {rx_shift_q, opnd_q[31:8]};
  assign is_arith   = (op_q == OpAdd) || (op_q == OpMul);
  assign resp_shift = acc_q >> {resp_idx_q, 3'b000};

  always_comb begin
    ctl_state_d = ctl_state_q;
    op_d        = op_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    mul_cnt_d   = mul_cnt_q;
    resp_idx_d  = resp_idx_q;
    fifo_push   = 1'b0;
    fifo_wdata  = rx_shift_q;
    if (mul_cnt_q != 6'd0) begin
      prod_d    = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_q >> 1;
      mul_cnt_d = mul_cnt_q - 6'd1;
      if (mul_cnt_q == 6'd1) acc_d = prod_d;
    end
    unique case (ctl_state_q)
      CtlIdle: if (rx_valid) begin
        op_d        = rx_shift_q;
        byte_cnt_d  = 16'd1;
        acc_d       = (rx_shift_q == OpMul) ? 32'd1 : 32'd0;
        ctl_state_d = CtlHdr;
      end
      CtlHdr: if (rx_valid) begin
        byte_cnt_d = byte_cnt_q + 16'd1;
        if (byte_cnt_q == 16'd2) len_d[7:0] = rx_shift_q;
        if (byte_cnt_q == 16'd3) begin
          len_d       = len_full;
          err_d       = !(op_q == OpEcho || is_arith) ||
                        (is_arith && (len_full < 16'd8 || len_full[1:0] != 2'b00));
          ctl_state_d = (len_full > 16'd4) ? CtlPayload : CtlIdle;
        end
      end
      CtlPayload: if (rx_valid) begin
        byte_cnt_d = byte_cnt_q + 16'd1;
        opnd_d     = opnd_new;
        if (op_q == OpEcho) begin
          fifo_push = 1'b1;
        end else if (!err_q && byte_cnt_q[1:0] == 2'b11) begin
          if (op_q == OpAdd) begin
            acc_d = acc_q + opnd_new;
          end else begin
            mcand_d   = acc_q;
            mplier_d  = opnd_new;
            prod_d    = 32'd0;
            mul_cnt_d = 6'd32;
          end
        end
        if (byte_cnt_q == len_q - 16'd1) begin
          resp_idx_d = 2'd0;
          if (err_q || op_q == OpEcho) ctl_state_d = CtlIdle;
          else if (op_q == OpMul)      ctl_state_d = CtlExec;
          else                         ctl_state_d = CtlResp;
        end
      end
      CtlExec: if (mul_cnt_q == 6'd0) ctl_state_d = CtlResp;
      CtlResp: if (!fifo_full) begin
        fifo_push  = 1'b1;
        fifo_wdata = resp_shift[7:0];
        resp_idx_d = resp_idx_q + 2'd1;
        if (resp_idx_q == 2'd3) ctl_state_d = CtlIdle;
      end
      default: ctl_state_d = CtlIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      fifo_cnt_q  <= '0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bits_q   <= '0;
      tx_shift_q  <= '1;
      tx_q        <= 1'b1;
      ctl_state_q <= CtlIdle;
      op_q        <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      mul_cnt_q   <= '0;
      resp_idx_q  <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_cnt_q  <= fifo_cnt_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bits_q   <= tx_bits_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      ctl_state_q <= ctl_state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      mul_cnt_q   <= mul_cnt_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
// Directed bench for uart_alu: drives serial packets on rx_i, decodes tx_o frames and
// compares response bytes against hand-computed values.
module tb_uart_alu;

  localparam int Bit = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] rxq[$];
  logic       stopq[$];
  logic [7:0] pkt[$];
  logic [7:0] mon_b;
  logic       mon_ok;

  always #5 clk = ~clk;

  uart_alu #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i (rx),
    .tx_o (tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame decoder: sample every bit at its midpoint, record data and stop-bit validity.
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (Bit / 2 - 1) @(negedge clk);
        mon_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (Bit) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (Bit) @(negedge clk);
        mon_ok = mon_ok && (tx === 1'b1);
        rxq.push_back(mon_b);
        stopq.push_back(mon_ok);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    rx = 1'b1;
    repeat (Bit) @(negedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  // Expect exactly n response bytes; exp_le holds them little-endian.
  task automatic expect_bytes(input string tag, input int n, input logic [31:0] exp_le);
    int t = 0;
    while (rxq.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (300) @(negedge clk);
    check_eq({tag, "_count"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (rxq.size() > 0) begin
        check_eq($sformatf("%s_b%0d", tag, i), rxq.pop_front(), exp_le[8*i +: 8]);
        check_eq($sformatf("%s_stop%0d", tag, i), stopq.pop_front(), 1);
      end
    end
    rxq.delete();
    stopq.delete();
  endtask

  initial begin
    logic [31:0] prod;
    logic [31:0] a;
    int          n;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("reset_tx", tx, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("idle_tx", tx, 1);

    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
    send_pkt();
    expect_bytes("echo4", 4, 32'h6942_6942);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_bytes("mul3x5", 4, 32'h0000_000F);

    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    send_pkt();
    expect_bytes("mul_trunc", 4, 32'h0000_0000);

    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    expect_bytes("add_wrap", 4, 32'h0000_0001);

    for (int k = 0; k < 3; k++) begin
      n    = 2 + (k % 2);
      prod = 32'd1;
      pkt  = '{8'h88, 8'h00, 8'(4 + 4 * n), 8'h00};
      for (int j = 0; j < n; j++) begin
        a    = $urandom;
        prod = prod * a;
        for (int m = 0; m < 4; m++) pkt.push_back(a[8*m +: 8]);
      end
      send_pkt();
      expect_bytes($sformatf("mul_fuzz%0d", k), 4, prod);
    end

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    expect_bytes("unknown_op", 0, 32'h0);

    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_pkt();
    expect_bytes("echo1", 1, 32'h0000_007E);

    pkt = '{8'h88, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt();
    expect_bytes("mul_badlen", 0, 32'h0);

    pkt = '{8'hEC, 8'h00};
    send_pkt();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("midpkt_rst_tx%0d", i), tx, 1);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("post_rst_tx", tx, 1);

    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h3C};
    send_pkt();
    expect_bytes("echo_after_rst", 1, 32'h0000_003C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
